perip_pwm_capture: RTL and testbench
====================================

// Module: perip_pwm_capture
// PURPOSE
// - Memory-mapped input-capture peripheral; the receive side of the LED/tone PWM path.
// - Samples an external pulse train (pwm_in) and measures its period and high time in clk cycles.
// - Exposes results on the same cs/rd/wr/addr peripheral bus used by the PWM generator.
// - The CPU reads frequency/duty of incoming signals or loop-checks its own PWM output.
// PARAMETERS
// - CNT_W        32          width of period/high/edge counters (saturating)
// - SYNC_STAGES  2           flops in pwm_in synchronizer (>=2)
// - TIMEOUT      50_000_000  cycles without a rising edge before the stall flag is raised
// PORTS
// - clk      in   1   system clock, all logic on posedge
// - reset    in   1   asynchronous, active-low reset
// - d_in     in   32  bus write data
// - cs       in   1   peripheral select
// - addr     in   32  byte address; only addr[4:0] decoded
// - rd       in   1   read strobe (qualified by cs)
// - wr       in   1   write strobe (qualified by cs)
// - d_out    out  32  registered read data
// - pwm_in   in   1   asynchronous pulse input
// - irq      out  1   level interrupt = STATUS.valid & CTRL.irq_en
// BEHAVIOUR
// - Register map (addr[4:0]):
//   - 0x00 CTRL RW: bit0 enable, bit1 irq_en.
//   - 0x04 STATUS: bit0 valid, bit1 overrun, bit2 stall (W1C on bits 0-2); bit3 sync level (RO).
//   - 0x08 PERIOD RO, 0x0C HIGH RO, 0x10 EDGES RO (rising edges since enable).
//   - Other offsets: reads return 0, writes ignored.
// - Reset: all registers, counters, d_out and irq = 0; sync chain = 0; armed = 0.
// - Read path:
//   - d_out is valid 1 cycle after cs&rd.
//   - d_out = 0 on any cycle without cs&rd.
//   - Reads have no side effects.
// - Sync/edge: pwm_in is passed through SYNC_STAGES flops, then a 1-flop edge detector.
//   - Rising-edge pulse is asserted SYNC_STAGES+1 cycles after the input transition.
// - Measurement, active only while enable=1:
//   - per_cnt increments every cycle.
//   - hi_cnt increments while sync level = 1.
//   - Both saturate at 2^CNT_W-1 and never wrap.
//   - First rising edge after enable: armed <= 1; counters cleared; no result produced.
//   - Each later rising edge, in the same cycle:
//     - PERIOD <= per_cnt+1 and HIGH <= hi_cnt, both saturating.
//     - per_cnt <= 0 and hi_cnt <= 0.
//     - valid <= 1; overrun <= 1 if valid was already 1 before this cycle.
//   - EDGES increments on every rising edge while enabled, saturating.
//   - stall <= 1 when armed and per_cnt reaches TIMEOUT. PERIOD/HIGH are kept.
//   - The next rising edge re-arms: no result, counters cleared. stall stays until W1C.
// - Simultaneous W1C of valid and a new capture in the same cycle:
//   - The set wins: valid = 1.
//   - Overrun is evaluated against the pre-clear value.
// - CTRL.enable 1->0:
//   - armed <= 0; counters held at 0; EDGES held.
//   - PERIOD, HIGH and STATUS are retained.
// - CTRL.enable 0->1: EDGES <= 0; per_cnt/hi_cnt restart from 0; the next rising edge only arms.
// - Reset asserted mid-measurement: immediate clear of all state. No partial result is visible.
// - A write to CTRL and an edge in the same cycle: the edge is processed with the old enable value.
// STRUCTURE
// - Shared package/include:
//   - Register offsets: OFF_CTRL, OFF_STATUS, OFF_PERIOD, OFF_HIGH, OFF_EDGES.
//   - Bit indices: CTRL_EN, CTRL_IRQ, ST_VALID, ST_OVR, ST_STALL, ST_LVL.
// - Sub-module sync_edge_det (params STAGES):
//   - Inputs: clk, reset, async_in.
//   - Outputs: level, rise, fall.
//   - Reused by future keyboard/encoder inputs.
// - Top level holds: bus decode, counters, capture registers, status/irq.
// TESTING
// - Reset: reset low mid-run, then high.
//   - All reads return 0; irq = 0.
//   - First rising edge after enable produces no valid.
// - Steady PWM, period 100 cycles, high 25, enable=1:
//   - After the 2nd rising edge, PERIOD=100, HIGH=25, valid=1.
//   - EDGES counts 2, 3, ... per period.
// - Overrun: leave valid set across 2 captures.
//   - overrun=1.
//   - Writing 0x3 to STATUS clears both bits; the next capture sets valid only.
// - Stall: TIMEOUT=1000, stop input after a capture with PERIOD=100.
//   - stall=1 at 1000 cycles after the last edge; PERIOD stays 100.
//   - Restarting the input gives a capture at the 2nd new edge.
// - Boundary: CNT_W=8, period 300.
//   - PERIOD=255 (saturated). HIGH also saturates if > 255.
//   - W1C of valid in the capture cycle leaves valid=1.
// - Bus: cs&rd at 0x14 and 0x1C returns 0.
//   - d_out is 0 the cycle after rd drops.
//   - irq follows valid only when irq_en=1.

Source files
------------

// File: rtl/perip_pwm_capture_pkg.sv
// Register map, bit positions and status layout shared by the PWM capture peripheral
// and its bench.
package perip_pwm_capture_pkg;
   localparam logic [4:0] OFF_CTRL   = 5'h00;
   localparam logic [4:0] OFF_STATUS = 5'h04;
   localparam logic [4:0] OFF_PERIOD = 5'h08;
   localparam logic [4:0] OFF_HIGH   = 5'h0C;
   localparam logic [4:0] OFF_EDGES  = 5'h10;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_IRQ = 1;
   localparam int ST_VALID = 0;
   localparam int ST_OVR   = 1;
   localparam int ST_STALL = 2;
   localparam int ST_LVL   = 3;

   typedef struct packed {
      logic stall;
      logic overrun;
      logic valid;
   } status_t;
endpackage

// File: rtl/perip_pwm_capture_sync_edge_det.sv
// Multi-flop synchronizer followed by a one-flop edge detector; level is the
// edge-detector flop so it lines up with the counting that follows a rise.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_reg;
   logic [STAGES-1:0] sync_next;
   logic              prev_reg;

   assign sync_next[0] = async_in;
   for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
      assign sync_next[gi] = sync_reg[gi-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= sync_next;
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign level = prev_reg;
   assign rise  = sync_reg[STAGES-1] & ~prev_reg;
   assign fall  = ~sync_reg[STAGES-1] & prev_reg;
endmodule

// File: rtl/perip_pwm_capture.sv
// PWM input-capture peripheral: measures period and high time of pwm_in in clk
// cycles and exposes results, status and an interrupt on the cs/rd/wr bus.
module perip_pwm_capture
   import perip_pwm_capture_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [31:0] addr,
   input  logic        rd,
   input  logic        wr,
   output logic [31:0] d_out,
   input  logic        pwm_in,
   output logic        irq
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             level, rise, fall_unused;
   logic             en_reg, en_next, irq_en_reg, irq_en_next, armed_reg, armed_next;
   status_t          status_reg, status_next;
   logic [CNT_W-1:0] per_cnt_reg, per_cnt_next, hi_cnt_reg, hi_cnt_next;
   logic [CNT_W-1:0] period_reg, period_next, high_reg, high_next, edges_reg, edges_next;
   logic [31:0]      d_out_reg, d_out_next, rdata;
   logic             ctrl_wr, status_wr, timeout_hit, capture, stall_set;
   logic [2:0]       w1c;
   logic             unused_bits;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == CNT_MAX) ? x : x + CNT_W'(1);
   endfunction

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (pwm_in),
      .level    (level),
      .rise     (rise),
      .fall     (fall_unused)
   );

   assign unused_bits = ^{addr[31:5], d_in[31:3]};
   assign ctrl_wr     = cs && wr && (addr[4:0] == OFF_CTRL);
   assign status_wr   = cs && wr && (addr[4:0] == OFF_STATUS);
   assign w1c         = status_wr ? d_in[2:0] : 3'b000;
   assign timeout_hit = 64'(per_cnt_reg) >= 64'(TIMEOUT);
   // Edges and timeouts are judged against the enable value in force before any CTRL write.
   assign capture     = en_reg && armed_reg && rise;
   assign stall_set   = en_reg && armed_reg && !rise && timeout_hit;

   always_comb begin
      en_next      = en_reg;
      irq_en_next  = irq_en_reg;
      armed_next   = armed_reg;
      per_cnt_next = per_cnt_reg;
      hi_cnt_next  = hi_cnt_reg;
      period_next  = period_reg;
      high_next    = high_reg;
      edges_next   = edges_reg;
      rdata        = '0;

      if (en_reg) begin
         per_cnt_next = sat_inc(per_cnt_reg);
         if (level) hi_cnt_next = sat_inc(hi_cnt_reg);
         if (rise) begin
            armed_next   = 1'b1;
            per_cnt_next = '0;
            hi_cnt_next  = '0;
            edges_next   = sat_inc(edges_reg);
            if (armed_reg) begin
               period_next = sat_inc(per_cnt_reg);
               high_next   = hi_cnt_reg;
            end
         end else if (armed_reg && timeout_hit) begin
            armed_next = 1'b0;
         end
      end

      // A capture in the same cycle as a W1C wins; overrun looks at the pre-clear valid.
      status_next.valid   = (status_reg.valid & ~w1c[ST_VALID]) | capture;
      status_next.overrun = (status_reg.overrun & ~w1c[ST_OVR]) | (capture & status_reg.valid);
      status_next.stall   = (status_reg.stall & ~w1c[ST_STALL]) | stall_set;

      if (ctrl_wr) begin
         en_next     = d_in[CTRL_EN];
         irq_en_next = d_in[CTRL_IRQ];
         if (!d_in[CTRL_EN] || !en_reg) begin
            armed_next   = 1'b0;
            per_cnt_next = '0;
            hi_cnt_next  = '0;
         end
         if (d_in[CTRL_EN] && !en_reg) edges_next = '0;
      end

      case (addr[4:0])
         OFF_CTRL: begin
            rdata[CTRL_EN]  = en_reg;
            rdata[CTRL_IRQ] = irq_en_reg;
         end
         OFF_STATUS: begin
            rdata[ST_VALID] = status_reg.valid;
            rdata[ST_OVR]   = status_reg.overrun;
            rdata[ST_STALL] = status_reg.stall;
            rdata[ST_LVL]   = level;
         end
         OFF_PERIOD: rdata = 32'(period_reg);
         OFF_HIGH:   rdata = 32'(high_reg);
         OFF_EDGES:  rdata = 32'(edges_reg);
         default:    rdata = '0;
      endcase
      d_out_next = (cs && rd) ? rdata : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_reg      <= 1'b0;
         irq_en_reg  <= 1'b0;
         armed_reg   <= 1'b0;
         status_reg  <= '0;
         per_cnt_reg <= '0;
         hi_cnt_reg  <= '0;
         period_reg  <= '0;
         high_reg    <= '0;
         edges_reg   <= '0;
         d_out_reg   <= '0;
      end else begin
         en_reg      <= en_next;
         irq_en_reg  <= irq_en_next;
         armed_reg   <= armed_next;
         status_reg  <= status_next;
         per_cnt_reg <= per_cnt_next;
         hi_cnt_reg  <= hi_cnt_next;
         period_reg  <= period_next;
         high_reg    <= high_next;
         edges_reg   <= edges_next;
         d_out_reg   <= d_out_next;
      end
   end

   assign d_out = d_out_reg;
   assign irq   = status_reg.valid & irq_en_reg;
endmodule

// File: tb/tb_perip_pwm_capture.sv
// Bench for perip_pwm_capture: a 32-bit instance (a) and an 8-bit instance (b), both with
// a 1000-cycle stall timeout, driven by PWM waveforms and bus transactions.
module tb_perip_pwm_capture;
   localparam logic [4:0] R_CTRL = 5'h00, R_STATUS = 5'h04, R_PERIOD = 5'h08;
   localparam logic [4:0] R_HIGH = 5'h0C, R_EDGES = 5'h10;

   typedef struct {
      int dut; int p; int h; int n;
      logic [31:0] e_per; logic [31:0] e_hi; logic [31:0] e_edges; logic [2:0] e_st;
   } vec_t;

   logic        clk = 1'b0, reset = 1'b0;
   logic [31:0] d_in = '0, addr = '0;
   logic        rd = 1'b0, wr = 1'b0, cs_a = 1'b0, cs_b = 1'b0, pwm_a = 1'b0, pwm_b = 1'b0;
   logic [31:0] dout_a, dout_b;
   logic        irq_a, irq_b;
   int          total = 0, bad = 0, cyc = 0, last_rise = 0;

   perip_pwm_capture #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_a (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_a), .addr(addr), .rd(rd), .wr(wr),
      .d_out(dout_a), .pwm_in(pwm_a), .irq(irq_a));
   perip_pwm_capture #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_b (
      .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_b), .addr(addr), .rd(rd), .wr(wr),
      .d_out(dout_b), .pwm_in(pwm_b), .irq(irq_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic sel(input int w, input logic on);
      cs_a = on && (w == 0);
      cs_b = on && (w == 1);
   endtask

   task automatic bus_write(input int w, input logic [4:0] a, input logic [31:0] data);
      addr = 32'(a); d_in = data; wr = 1'b1; sel(w, 1'b1);
      tick(1);
      wr = 1'b0; d_in = '0; sel(w, 1'b0);
   endtask

   task automatic bus_read(input int w, input logic [4:0] a, output logic [31:0] data);
      addr = 32'(a); rd = 1'b1; sel(w, 1'b1);
      tick(1);
      data = (w == 0) ? dout_a : dout_b;
      rd = 1'b0; sel(w, 1'b0);
   endtask

   task automatic set_pwm(input int w, input logic v);
      if (w == 0) pwm_a = v; else pwm_b = v;
   endtask

   task automatic drive_pwm(input int w, input int p, input int h, input int n);
      for (int k = 0; k < n; k++) begin
         set_pwm(w, 1'b1); last_rise = cyc;
         tick(h);
         set_pwm(w, 1'b0);
         tick(p - h);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Fresh enable, n full PWM periods, then read back the measurement registers.
   task automatic run_session(input int w, input int p, input int h, input int n,
                              output logic [31:0] per, output logic [31:0] hi,
                              output logic [31:0] edg, output logic [31:0] st);
      bus_write(w, R_CTRL, 32'h0);
      bus_write(w, R_STATUS, 32'h7);
      bus_write(w, R_CTRL, 32'h1);
      tick(4);
      drive_pwm(w, p, h, n);
      bus_read(w, R_PERIOD, per);
      bus_read(w, R_HIGH, hi);
      bus_read(w, R_EDGES, edg);
      bus_read(w, R_STATUS, st);
      $display("session dut=%0d P=%0d H=%0d N=%0d -> period=%0d high=%0d edges=%0d status=0x%0h",
               w, p, h, n, per, hi, edg, st);
   endtask

   // Reference: a full period measures P cycles and H high cycles, clipped to the counter range.
   function automatic logic [31:0] model_sat(input int w, input int v);
      return (w == 1 && v > 255) ? 32'd255 : 32'(v);
   endfunction

   initial begin
      vec_t        vecs[8];
      logic [31:0] per, hi, edg, st, rv;
      logic [2:0]  exp_st;
      int          w, p, h, n, pulses, seen, delta;

      vecs[0] = '{0, 100, 25, 2, 32'd100, 32'd25, 32'd2, 3'b001};
      vecs[1] = '{0, 100, 25, 4, 32'd100, 32'd25, 32'd4, 3'b011};
      vecs[2] = '{0, 37, 1, 3, 32'd37, 32'd1, 32'd3, 3'b011};
      vecs[3] = '{0, 50, 49, 2, 32'd50, 32'd49, 32'd2, 3'b001};
      vecs[4] = '{1, 300, 100, 2, 32'd255, 32'd100, 32'd2, 3'b001};
      vecs[5] = '{1, 300, 260, 2, 32'd255, 32'd255, 32'd2, 3'b001};
      vecs[6] = '{1, 255, 254, 2, 32'd255, 32'd254, 32'd2, 3'b001};
      vecs[7] = '{1, 100, 25, 3, 32'd100, 32'd25, 32'd3, 3'b011};

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      tick(2);
      check("rst_irq_a", 32'(irq_a), 0);
      check("rst_irq_b", 32'(irq_b), 0);
      check("rst_dout_a", dout_a, 0);
      for (int r = 0; r < 5; r++) begin
         bus_read(0, 5'(r * 4), rv);
         check("rst_read_a", rv, 0);
      end

      // Table-driven captures
      for (int i = 0; i < 8; i++) begin
         run_session(vecs[i].dut, vecs[i].p, vecs[i].h, vecs[i].n, per, hi, edg, st);
         check("tbl_period", per, vecs[i].e_per);
         check("tbl_high", hi, vecs[i].e_hi);
         check("tbl_edges", edg, vecs[i].e_edges);
         check("tbl_status", 32'(st[2:0]), 32'(vecs[i].e_st));
      end

      // Bus decode, read timing, ignored writes and irq gating
      run_session(0, 100, 25, 2, per, hi, edg, st);
      bus_read(0, 5'h14, rv);      check("read_0x14", rv, 0);
      bus_read(0, 5'h1C, rv);      check("read_0x1C", rv, 0);
      bus_read(0, R_PERIOD, rv);   check("read_period", rv, 100);
      tick(1);                     check("dout_after_rd", dout_a, 0);
      bus_write(0, R_PERIOD, 32'hDEAD);
      bus_read(0, R_PERIOD, rv);   check("period_ro", rv, 100);
      check("irq_en0", 32'(irq_a), 0);
      bus_write(0, R_CTRL, 32'h3); check("irq_en1", 32'(irq_a), 1);
      bus_read(0, R_CTRL, rv);     check("ctrl_readback", rv, 3);
      bus_write(0, R_STATUS, 32'h1); check("irq_after_w1c", 32'(irq_a), 0);

      // Disable keeps results and EDGES; edges while disabled are ignored
      run_session(0, 100, 25, 3, per, hi, edg, st);
      bus_write(0, R_CTRL, 32'h0);
      drive_pwm(0, 40, 10, 2);
      bus_read(0, R_PERIOD, rv);   check("dis_period", rv, 100);
      bus_read(0, R_EDGES, rv);    check("dis_edges", rv, 3);
      bus_read(0, R_STATUS, rv);   check("dis_status", 32'(rv[2:0]), 3);

      // Overrun, W1C of valid+overrun, then a single capture sets valid only
      run_session(0, 60, 20, 3, per, hi, edg, st);
      check("ovr_status", 32'(st[2:0]), 3);
      bus_write(0, R_STATUS, 32'h3);
      bus_read(0, R_STATUS, rv);   check("ovr_cleared", 32'(rv[2:0]), 0);
      drive_pwm(0, 60, 20, 1);
      bus_read(0, R_STATUS, rv);   check("valid_only", 32'(rv[2:0]), 1);

      // W1C of valid held through a capture: valid must appear for exactly one cycle
      run_session(1, 100, 25, 2, per, hi, edg, st);
      check("w1c_setup", 32'(st[0]), 1);
      bus_write(1, R_CTRL, 32'h3); check("irq_b_on", 32'(irq_b), 1);
      addr = 32'(R_STATUS); d_in = 32'h1; wr = 1'b1; sel(1, 1'b1);
      tick(1);                     check("irq_b_cleared", 32'(irq_b), 0);
      set_pwm(1, 1'b1);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (irq_b) pulses++;
      end
      wr = 1'b0; d_in = '0; sel(1, 1'b0); set_pwm(1, 1'b0);
      check("w1c_vs_capture", 32'(pulses), 1);
      tick(10);

      // Stall after 1000 idle cycles; PERIOD kept; restart captures on the 2nd new edge
      run_session(0, 100, 25, 2, per, hi, edg, st);
      check("stall_setup_period", per, 100);
      while ((cyc - last_rise) < 900) tick(1);
      bus_read(0, R_STATUS, rv);   check("no_stall_early", 32'(rv[2]), 0);
      seen = 0; delta = 0;
      while (seen == 0 && (cyc - last_rise) < 1100) begin
         bus_read(0, R_STATUS, rv);
         if (rv[2]) begin seen = 1; delta = cyc - last_rise; end
      end
      check("stall_seen", 32'(seen), 1);
      if (seen == 1 && (delta < 995 || delta > 1010))
         check("stall_delay", 32'(delta), 1000);
      bus_read(0, R_PERIOD, rv);   check("stall_period_kept", rv, 100);
      bus_write(0, R_STATUS, 32'h1);
      drive_pwm(0, 100, 25, 1);
      bus_read(0, R_STATUS, rv);   check("rearm_no_valid", 32'(rv[2:0]), 4);
      drive_pwm(0, 100, 25, 2);
      bus_read(0, R_PERIOD, rv);   check("restart_period", rv, 100);
      bus_read(0, R_STATUS, rv);   check("restart_status", 32'(rv[2:0]), 7);

      // Randomized sessions against the reference model
      for (int i = 0; i < 12; i++) begin
         w = int'($urandom_range(0, 1));
         p = (w == 1) ? int'($urandom_range(150, 400)) : int'($urandom_range(8, 300));
         h = int'($urandom_range(1, p - 1));
         n = int'($urandom_range(2, 5));
         run_session(w, p, h, n, per, hi, edg, st);
         exp_st = {1'b0, (n >= 3), (n >= 2)};
         check("rand_period", per, model_sat(w, p));
         check("rand_high", hi, model_sat(w, h));
         check("rand_edges", edg, 32'(n));
         check("rand_status", 32'(st[2:0]), 32'(exp_st));
      end

      // Reset in the middle of a measurement clears everything
      bus_write(0, R_CTRL, 32'h0);
      bus_write(0, R_STATUS, 32'h7);
      bus_write(0, R_CTRL, 32'h3);
      drive_pwm(0, 50, 20, 3);
      check("pre_reset_irq", 32'(irq_a), 1);
      set_pwm(0, 1'b1);
      tick(10);
      reset = 1'b0;
      tick(3);
      check("mid_rst_irq", 32'(irq_a), 0);
      check("mid_rst_dout", dout_a, 0);
      set_pwm(0, 1'b0);
      reset = 1'b1;
      tick(4);
      for (int r = 0; r < 5; r++) begin
         bus_read(0, 5'(r * 4), rv);
         check("post_rst_read", rv, 0);
      end
      bus_write(0, R_CTRL, 32'h1);
      tick(4);
      drive_pwm(0, 50, 20, 1);
      bus_read(0, R_STATUS, rv);   check("first_edge_no_valid", 32'(rv[0]), 0);
      bus_read(0, R_EDGES, rv);    check("first_edge_count", rv, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
